fb_fetch_ctrl: RTL
==================

# fb_fetch_ctrl

Framebuffer fetch controller sitting between the VGA timing generator and the external RP2040 framebuffer pins. It drives the RP2040 handshake: a frame-pointer reset pulse at frame start, then paced next-pixel strobes. It samples the returned 4-bit gray nibbles into a small prefetch FIFO and hands one pixel to the VGA output stage per pixel request. It also flags underflow when the RP2040 cannot keep up.

## Interface
Parameters:
- FIFO_DEPTH, 4: prefetch entries (power of two, 2..16)
- STROBE_HIGH, 2: cycles `frame_next_pixel_out` is held high per fetch (≥1)
- STROBE_LOW, 2: cycles it is held low after each high phase (≥1)
- RST_CYCLES, 4: cycles `frame_reset_out` is held high (≥1)
- FRAME_PIXELS, 76800: pixels fetched per frame; fetching stops after this count

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new fetch strobes; low = finish current strobe, then idle
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank
- pix_req  in  1  one-cycle pulse per displayed pixel (active video only)
- frame_pixel_in  in  4  gray nibble from RP2040
- frame_next_pixel_out  out  1  fetch strobe to RP2040
- frame_reset_out  out  1  frame-pointer reset to RP2040
- gray_out  out  4  pixel value to VGA output stage
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underflow  out  1  sticky: a pix_req found the FIFO empty this frame

## Operation
- FSM states: IDLE, RST_PULSE, WAIT, STROBE_HI, STROBE_LO. A phase counter times each state; a fetch counter counts fetched pixels.
- Reset: state IDLE; FIFO empty; counters 0; all outputs 0.
- IDLE: no strobes. `frame_start`=1 → RST_PULSE. Nothing is fetched before the first `frame_start` after reset.
- `frame_start` in any state has top priority:
  - flush the FIFO;
  - clear the fetch counter and `underflow`;
  - abort any strobe in progress, with no sample taken;
  - enter RST_PULSE.
- RST_PULSE: lasts RST_CYCLES cycles, then → WAIT.
- WAIT: go to STROBE_HI when all of these hold:
  - `enable`=1;
  - `fifo_level` < FIFO_DEPTH;
  - fetch counter < FRAME_PIXELS.
- WAIT with fetch counter == FRAME_PIXELS: → IDLE.
- STROBE_HI: lasts STROBE_HIGH cycles, then → STROBE_LO.
- STROBE_LO: lasts STROBE_LOW cycles. On its last cycle:
  - sample `frame_pixel_in`, push it into the FIFO, increment the fetch counter;
  - go directly to STROBE_HI if the WAIT conditions hold using the post-push level and count;
  - otherwise go to WAIT.
- At most one fetch is in flight and a strobe starts only with space free, so a push never overflows.
- pix_req with FIFO non-empty: pop; `gray_out` <= head entry.
- pix_req with FIFO empty: `gray_out` <= 0; `underflow` <= 1; nothing popped.
- Without pix_req, `gray_out` holds its value.
- Push and pop in the same cycle:
  - Both take effect and the level is unchanged.
  - If the FIFO was empty, the pop sees empty: underflow, `gray_out`=0, and the pushed value is stored.
- `enable` falling mid-strobe: the current fetch completes, including its push; then WAIT.

## Timing
- All outputs are registered; strobes are glitch-free.
- `frame_start` sampled at edge t: `frame_reset_out`=1 for cycles t+1 … t+RST_CYCLES.
- First `frame_next_pixel_out` rise: cycle t+RST_CYCLES+2 (one WAIT cycle).
- Sustained fetch rate: one pixel per STROBE_HIGH+STROBE_LOW cycles (default 4).
- The RP2040 has STROBE_HIGH+STROBE_LOW−1 cycles from strobe rise to present data. Sampling is on the last STROBE_LO cycle; `fifo_level` reflects the push on the next cycle.
- `gray_out`: updates the cycle after pix_req (latency 1).
- `fifo_level`, `underflow`: valid the cycle after the event that changes them.
- Asynchronous reset mid-strobe: `frame_next_pixel_out` and `frame_reset_out` drop immediately.

## Test plan
- Reset, then `frame_start`: `frame_reset_out` high for exactly 4 cycles. First strobe rises 2 cycles after reset ends. Strobe pattern is 2 high / 2 low.
- FRAME_PIXELS=6, RP2040 model returns 1,2,…; no pix_req: exactly 4 fetches; `fifo_level`=4; strobes stop. Pop one → one more strobe. After 6 total fetches the FSM goes IDLE.
- Steady pix_req every 8 cycles over 6 pixels: `gray_out` sequence 1..6, each 1 cycle after its pix_req; `underflow` stays 0.
- pix_req every cycle from frame start: first pix_req sees empty → `gray_out`=0, `underflow`=1. `underflow` clears at the next `frame_start`.
- `frame_start` during a STROBE_HI: strobe drops the next cycle; `fifo_level`=0; no sample pushed; new reset pulse of 4 cycles.
- `enable`=0 mid-STROBE_HI: that fetch completes and pushes; no further strobes until `enable`=1.

Source files
------------

// File: rtl/fb_fetch_ctrl.sv
// Framebuffer fetch controller: paces RP2040 next-pixel strobes after a frame-pointer
// reset, buffers returned gray nibbles in a small FIFO and serves one pixel per pix_req.
module fb_fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STROBE_HIGH  = 2,
    parameter int unsigned STROBE_LOW   = 2,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned FRAME_PIXELS = 76800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        frame_start,
    input  logic                        pix_req,
    input  logic [3:0]                  frame_pixel_in,
    output logic                        frame_next_pixel_out,
    output logic                        frame_reset_out,
    output logic [3:0]                  gray_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned PH_MAX = (RST_CYCLES > STROBE_HIGH)
                                     ? ((RST_CYCLES > STROBE_LOW) ? RST_CYCLES : STROBE_LOW)
                                     : ((STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_PULSE = 3'd1,
        S_WAIT      = 3'd2,
        S_STROBE_HI = 3'd3,
        S_STROBE_LO = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               strobe_q, strobe_d;
    logic               rst_out_q, rst_out_d;

    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [3:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [3:0]         gray_q, gray_d;
    logic               under_q, under_d;

    logic               push_c;
    logic               pop_c;

    // Sample lands on the last STROBE_LO cycle unless a frame restart aborts it.
    assign push_c = (state_q == S_STROBE_LO) && (phase_q == PH_W'(STROBE_LOW - 1)) && !frame_start;
    assign pop_c  = pix_req && !frame_start && (level_q != '0);

    always_comb begin : fifo_next
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        gray_d   = gray_q;
        under_d  = under_q;
        if (frame_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            under_d  = 1'b0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = frame_pixel_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            // An empty FIFO reports underflow even if a push lands this same cycle.
            if (pix_req) begin
                if (level_q != '0) begin
                    gray_d   = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end else begin
                    gray_d  = 4'h0;
                    under_d = 1'b1;
                end
            end
            level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        rst_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RST_PULSE: begin
                if (phase_q == PH_W'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q >= CNT_W'(FRAME_PIXELS)) begin
                    state_d = S_IDLE;
                end else if (enable && (level_q < LVL_W'(FIFO_DEPTH))) begin
                    state_d = S_STROBE_HI;
                    phase_d = '0;
                end
            end
            S_STROBE_HI: begin
                if (phase_q == PH_W'(STROBE_HIGH - 1)) begin
                    state_d = S_STROBE_LO;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_STROBE_LO: begin
                if (phase_q == PH_W'(STROBE_LOW - 1)) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    phase_d = '0;
                    // Back-to-back fetch judged on the post-push level and count.
                    if (enable && (level_d < LVL_W'(FIFO_DEPTH)) && (cnt_d < CNT_W'(FRAME_PIXELS))) begin
                        state_d = S_STROBE_HI;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
        if (frame_start) begin
            state_d = S_RST_PULSE;
            phase_d = '0;
            cnt_d   = '0;
        end
        strobe_d  = (state_d == S_STROBE_HI);
        rst_out_d = (state_d == S_RST_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            strobe_q  <= 1'b0;
            rst_out_q <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gray_q    <= 4'h0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            strobe_q  <= strobe_d;
            rst_out_q <= rst_out_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            gray_q    <= gray_d;
            under_q   <= under_d;
        end
    end

    assign frame_next_pixel_out = strobe_q;
    assign frame_reset_out      = rst_out_q;
    assign gray_out             = gray_q;
    assign fifo_level           = level_q;
    assign underflow            = under_q;

endmodule
